// File: rtl/field_select_pkg.sv
// Shared definitions for the field-select FSM: state encoding,
// button event bundle and index-width helper.
package field_select_pkg;

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_ADJUST = 1'b1;

    typedef struct packed {
        logic left;
        logic right;
        logic center;
    } btn_ev_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/field_select_fsm_edge_detect.sv
// One-bit rising-edge detector; the previous-sample register clears
// on reset so a level held through reset yields one edge afterwards.
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic in_i,
    output logic edge_o
);

    logic prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= in_i;
        end
    end

    assign edge_o = in_i & ~prev_q;

endmodule

// File: rtl/field_select_fsm.sv
// Button-driven field selector with RUN/ADJUST modes.
// Define FIELD_SELECT_TIMEOUT_EN for inactivity auto-exit from ADJUST.
module field_select_fsm
    import field_select_pkg::*;
#(
    parameter int NUM_FIELDS     = 5,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int WRAP           = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                left,
    input  logic                                right,
    input  logic                                center,
    output logic                                adjust,
    output logic [NUM_FIELDS-1:0]               EN,
    output logic [idx_width(NUM_FIELDS)-1:0]    field_idx,
    output logic                                timeout_pulse
);

    localparam int IW = idx_width(NUM_FIELDS);
    localparam logic [IW-1:0] IDX_MAX = IW'(NUM_FIELDS - 1);

    if (NUM_FIELDS < 2 || NUM_FIELDS > 16 ||
        TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > (1 << 20)) begin : g_bad_param
        $fatal(1, "field_select_fsm: parameter out of range");
    end

    btn_ev_t ev;

    edge_detect u_ed_left (
        .clk    (clk),
        .rst    (rst),
        .in_i   (left),
        .edge_o (ev.left)
    );

    edge_detect u_ed_right (
        .clk    (clk),
        .rst    (rst),
        .in_i   (right),
        .edge_o (ev.right)
    );

    edge_detect u_ed_center (
        .clk    (clk),
        .rst    (rst),
        .in_i   (center),
        .edge_o (ev.center)
    );

    logic [0:0]            state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [NUM_FIELDS-1:0] en_q, en_d;
    logic                  tmo_q, tmo_d;
    logic                  tmo_fire;

`ifdef FIELD_SELECT_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 2);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          ev_any;

    assign ev_any   = ev.left | ev.right | ev.center;
    // Fires on the idle cycle that would bring the count to TIMEOUT_CYCLES-1.
    assign tmo_fire = (state_q == ST_ADJUST) && !ev_any &&
                      (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (state_q != ST_ADJUST || ev_any || tmo_fire) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign tmo_fire = 1'b0;
`endif

    function automatic logic [IW-1:0] idx_inc(input logic [IW-1:0] i);
        if (i == IDX_MAX) begin
            return (WRAP != 0) ? '0 : i;
        end
        return i + IW'(1);
    endfunction

    function automatic logic [IW-1:0] idx_dec(input logic [IW-1:0] i);
        if (i == '0) begin
            return (WRAP != 0) ? IDX_MAX : i;
        end
        return i - IW'(1);
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tmo_d   = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (ev.center) begin
                    state_d = ST_ADJUST;
                    idx_d   = '0;
                end
            end
            ST_ADJUST: begin
                // Center wins; left+right together cancel out.
                unique case (1'b1)
                    ev.center: begin
                        state_d = ST_RUN;
                        idx_d   = '0;
                    end
                    (ev.right && !ev.left): begin
                        idx_d = idx_inc(idx_q);
                    end
                    (ev.left && !ev.right): begin
                        idx_d = idx_dec(idx_q);
                    end
                    tmo_fire: begin
                        state_d = ST_RUN;
                        idx_d   = '0;
                        tmo_d   = 1'b1;
                    end
                    default: begin
                        idx_d = idx_q;
                    end
                endcase
            end
            default: begin
                state_d = ST_RUN;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        en_d = '0;
        if (state_d == ST_ADJUST) begin
            for (int i = 0; i < NUM_FIELDS; i++) begin
                en_d[i] = (idx_d == IW'(i));
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            idx_q   <= '0;
            en_q    <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            en_q    <= en_d;
            tmo_q   <= tmo_d;
        end
    end

    assign adjust        = (state_q == ST_ADJUST);
    assign EN            = en_q;
    assign field_idx     = idx_q;
    assign timeout_pulse = tmo_q;

endmodule

// File: tb/tb_field_select_fsm.sv
// Directed bench: wrapping, saturating and short-timeout instances
// driven by the same buttons.
module tb_field_select_fsm;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic left = 1'b0;
    logic right = 1'b0;
    logic center = 1'b0;

    logic       a_adj, s_adj, t_adj;
    logic [4:0] a_en, s_en, t_en;
    logic [2:0] a_idx, s_idx, t_idx;
    logic       a_tp, s_tp, t_tp;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    field_select_fsm #(.NUM_FIELDS(5), .TIMEOUT_CYCLES(1000), .WRAP(1)) u_wrap (
        .clk(clk), .rst(rst), .left(left), .right(right), .center(center),
        .adjust(a_adj), .EN(a_en), .field_idx(a_idx), .timeout_pulse(a_tp)
    );

    field_select_fsm #(.NUM_FIELDS(5), .TIMEOUT_CYCLES(1000), .WRAP(0)) u_sat (
        .clk(clk), .rst(rst), .left(left), .right(right), .center(center),
        .adjust(s_adj), .EN(s_en), .field_idx(s_idx), .timeout_pulse(s_tp)
    );

    field_select_fsm #(.NUM_FIELDS(5), .TIMEOUT_CYCLES(8), .WRAP(1)) u_tmo (
        .clk(clk), .rst(rst), .left(left), .right(right), .center(center),
        .adjust(t_adj), .EN(t_en), .field_idx(t_idx), .timeout_pulse(t_tp)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic adj,
                         input logic [4:0] en, input logic [2:0] idx);
        chk({tag, " wrap adjust"}, 32'(a_adj), 32'(adj));
        chk({tag, " wrap EN"}, 32'(a_en), 32'(en));
        chk({tag, " wrap idx"}, 32'(a_idx), 32'(idx));
    endtask

    task automatic chk_s(input string tag, input logic adj,
                         input logic [4:0] en, input logic [2:0] idx);
        chk({tag, " sat adjust"}, 32'(s_adj), 32'(adj));
        chk({tag, " sat EN"}, 32'(s_en), 32'(en));
        chk({tag, " sat idx"}, 32'(s_idx), 32'(idx));
    endtask

    task automatic press(input logic l, input logic r, input logic c);
        left = l;
        right = r;
        center = c;
        @(negedge clk);
        left = 1'b0;
        right = 1'b0;
        center = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    logic [2:0] exp_wr [5];
    logic [4:0] exp_we [5];
    logic [2:0] exp_sr [5];
    logic [4:0] exp_se [5];
    logic [2:0] exp_wl [5];
    logic [4:0] exp_wle [5];
    logic [2:0] exp_sl [5];
    logic [4:0] exp_sle [5];

    initial begin
        exp_wr  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
        exp_we  = '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
        exp_sr  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
        exp_se  = '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b10000};
        exp_wl  = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        exp_wle = '{5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001};
        exp_sl  = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
        exp_sle = '{5'b01000, 5'b00100, 5'b00010, 5'b00001, 5'b00001};

        // reset behaviour
        #3 rst = 1'b0;
        #1;
        chk_a("in reset", 1'b0, 5'b00000, 3'd0);
        chk("in reset tp", 32'(a_tp), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_a("after reset", 1'b0, 5'b00000, 3'd0);
        chk_s("after reset", 1'b0, 5'b00000, 3'd0);

        // left/right ignored in RUN
        press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        chk_a("run ignores lr", 1'b0, 5'b00000, 3'd0);

        // center held: single entry
        center = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_a("center held", 1'b1, 5'b00001, 3'd0);
        end
        center = 1'b0;
        @(negedge clk);
        chk_a("center released", 1'b1, 5'b00001, 3'd0);

        // right held: single step
        right = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_a("right held", 1'b1, 5'b00010, 3'd1);
        end
        right = 1'b0;
        @(negedge clk);

        // exit, then re-enter at idx 0
        press(1'b0, 1'b0, 1'b1);
        chk_a("center exit", 1'b0, 5'b00000, 3'd0);
        press(1'b0, 1'b0, 1'b1);
        chk_s("re-enter", 1'b1, 5'b00001, 3'd0);

        for (int i = 0; i < 5; i++) begin
            press(1'b0, 1'b1, 1'b0);
            chk_a("right step", 1'b1, exp_we[i], exp_wr[i]);
            chk_s("right step", 1'b1, exp_se[i], exp_sr[i]);
        end

        for (int i = 0; i < 5; i++) begin
            press(1'b1, 1'b0, 1'b0);
            chk_a("left step", 1'b1, exp_wle[i], exp_wl[i]);
            chk_s("left step", 1'b1, exp_sle[i], exp_sl[i]);
        end

        // simultaneous edges at idx 2
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        chk_a("to idx2", 1'b1, 5'b00100, 3'd2);
        press(1'b1, 1'b1, 1'b0);
        chk_a("left+right", 1'b1, 5'b00100, 3'd2);
        chk_s("left+right", 1'b1, 5'b00100, 3'd2);
        press(1'b1, 1'b1, 1'b1);
        chk_a("all three", 1'b0, 5'b00000, 3'd0);
        chk_s("all three", 1'b0, 5'b00000, 3'd0);

        // async reset mid-ADJUST at idx 3
        press(1'b0, 1'b0, 1'b1);
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        chk_a("to idx3", 1'b1, 5'b01000, 3'd3);
        center = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk_a("async reset", 1'b0, 5'b00000, 3'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_a("held center after reset", 1'b1, 5'b00001, 3'd0);
        @(negedge clk);
        chk_a("held center no repeat", 1'b1, 5'b00001, 3'd0);
        center = 1'b0;
        do_reset();

        // inactivity timeout, TIMEOUT_CYCLES=8
        center = 1'b1;
        @(negedge clk);
        center = 1'b0;
        chk("tmo entry adjust", 32'(t_adj), 32'd1);
        repeat (6) @(negedge clk);
        chk("tmo c6 adjust", 32'(t_adj), 32'd1);
        chk("tmo c6 pulse", 32'(t_tp), 32'd0);
        @(negedge clk);
`ifdef FIELD_SELECT_TIMEOUT_EN
        chk("tmo c7 pulse", 32'(t_tp), 32'd1);
        chk("tmo c7 adjust", 32'(t_adj), 32'd0);
        chk("tmo c7 EN", 32'(t_en), 32'd0);
        @(negedge clk);
        chk("tmo c8 pulse", 32'(t_tp), 32'd0);
`else
        chk("tmo c7 pulse", 32'(t_tp), 32'd0);
        chk("tmo c7 adjust", 32'(t_adj), 32'd1);
        @(negedge clk);
        chk("tmo c8 adjust", 32'(t_adj), 32'd1);
`endif
        do_reset();

        // right pulse at cycle 5 restarts the count
        center = 1'b1;
        @(negedge clk);
        center = 1'b0;
        repeat (4) @(negedge clk);
        right = 1'b1;
        @(negedge clk);
        right = 1'b0;
        chk("restart idx", 32'(t_idx), 32'd1);
        repeat (6) @(negedge clk);
        chk("restart c11 adjust", 32'(t_adj), 32'd1);
        chk("restart c11 pulse", 32'(t_tp), 32'd0);
        @(negedge clk);
`ifdef FIELD_SELECT_TIMEOUT_EN
        chk("restart c12 pulse", 32'(t_tp), 32'd1);
        chk("restart c12 idx", 32'(t_idx), 32'd0);
        chk("restart c12 adjust", 32'(t_adj), 32'd0);
`else
        chk("restart c12 pulse", 32'(t_tp), 32'd0);
        chk("restart c12 adjust", 32'(t_adj), 32'd1);
`endif
        chk("wrap dut tp", 32'(a_tp), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/field_select_fsm.md
FIELD_SELECT_FSM -- requirements
Module: field_select_fsm

Interface
REQ-001 SHALL have parameter NUM_FIELDS, default 5: number of adjustable fields, legal range 2..16.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000: idle cycles in ADJUST before auto-exit, legal range 2..2^20.
REQ-003 SHALL have parameter WRAP, default 1: 1 = field index wraps at ends, 0 = index saturates at ends.
REQ-004 SHALL have one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port: clk  input  1  system clock, all state on rising edge.
REQ-006 SHALL have port: rst  input  1  asynchronous active-low reset.
REQ-007 SHALL have port: left  input  1  synchronous debounced level, select previous field.
REQ-008 SHALL have port: right  input  1  synchronous debounced level, select next field.
REQ-009 SHALL have port: center  input  1  synchronous debounced level, enter/exit adjust mode.
REQ-010 SHALL have port: adjust  output  1  high while in ADJUST state.
REQ-011 SHALL have port: EN  output  NUM_FIELDS  one-hot field enable, bit i = field i selected.
REQ-012 SHALL have port: field_idx  output  clog2(NUM_FIELDS)  binary index of selected field.
REQ-013 SHALL have port: timeout_pulse  output  1  one-cycle pulse when auto-exit fires.

Function
REQ-014 SHALL detect rising edges on left/right/center using a registered copy of each input; edge = input high and previous sample low; held levels SHALL produce exactly one event.
REQ-015 SHALL implement two states: RUN (adjust=0, EN=0) and ADJUST (adjust=1, EN=one-hot of field_idx).
REQ-016 RUN: center edge SHALL move to ADJUST with field_idx=0; left/right edges SHALL be ignored.
REQ-017 ADJUST: right edge SHALL increment field_idx; at NUM_FIELDS-1 it SHALL go to 0 if WRAP=1, else hold.
REQ-018 ADJUST: left edge SHALL decrement field_idx; at 0 it SHALL go to NUM_FIELDS-1 if WRAP=1, else hold.
REQ-019 ADJUST: center edge SHALL return to RUN; field_idx SHALL reset to 0.
REQ-020 Simultaneous edges SHALL resolve: center has priority over left/right; left and right together SHALL leave field_idx unchanged.
REQ-021 Outputs SHALL be registered (Moore); effect of an edge SHALL be visible after the same rising clk edge that samples the input high.
REQ-022 EN SHALL be exactly one-hot in ADJUST and all-zero in RUN on every cycle; field_idx SHALL never exceed NUM_FIELDS-1.

Reset
REQ-023 rst low SHALL immediately force RUN, adjust=0, EN=0, field_idx=0, timeout_pulse=0, timeout counter=0, edge registers=0.
REQ-024 rst asserted mid-ADJUST SHALL abort adjustment; after release, a button already held high SHALL register as an edge on the first sampling cycle.

Configuration
REQ-025 Macro FIELD_SELECT_TIMEOUT_EN defined: inactivity counter SHALL count cycles in ADJUST with no edge, clear on any edge or on entering ADJUST, and on reaching TIMEOUT_CYCLES-1 SHALL return to RUN, clear field_idx, and pulse timeout_pulse for one cycle.
REQ-026 Macro FIELD_SELECT_TIMEOUT_EN undefined: no counter logic SHALL exist, ADJUST persists until center edge or reset, timeout_pulse SHALL be tied 0.

Structure
REQ-027 Shared package field_select_pkg SHALL hold the state encoding (RUN=0, ADJUST=1) and the index-width helper function.
REQ-028 One sub-module edge_detect (1-bit rising-edge detector, clk/rst) SHALL be instantiated three times.

Verification
REQ-029 Reset low then high, no buttons -> adjust=0, EN=5'b00000, field_idx=0.
REQ-030 center held 5 cycles -> adjust=1, EN=5'b00001 once; right held 5 cycles -> EN=5'b00010 (single step only).
REQ-031 WRAP=1, NUM_FIELDS=5, five right pulses from idx 0 -> idx 1,2,3,4,0; one left pulse at 0 -> idx 4, EN=5'b10000; WRAP=0 repeats -> saturate at 4 and 0.
REQ-032 center, left and right edges in same cycle during ADJUST at idx 2 -> RUN, EN=0, idx=0; left+right only -> idx stays 2.
REQ-033 FIELD_SELECT_TIMEOUT_EN, TIMEOUT_CYCLES=8, enter ADJUST, no input -> timeout_pulse high for one cycle 7 cycles after entry, adjust=0; right pulse at cycle 5 restarts count.
REQ-034 rst pulsed low while ADJUST at idx 3 -> adjust=0, EN=0 immediately, without waiting for clk.
